noc_credit_link_tx: RTL

// - Upstream (sending) end of the router-to-router credit link. Feeds one router input port
//   (data/dest/is_tail/send in, credit out) from a valid/ready flit stream.
// - Tracks the downstream flit-buffer credits and throttles the source when no credits remain.
// - Enforces wormhole dest consistency: every flit of a packet carries the head flit's dest.
// - Placed between a serializer shim or local source and a router link on clk_noc.

---
 rtl/noc_link_pkg.sv | 29 ++
 rtl/noc_credit_counter.sv | 46 ++++
 rtl/noc_credit_link_tx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/noc_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_link_pkg
// Purpose  : Shared types and helpers for the NoC credit link transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package noc_link_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } tx_state_e;

    localparam int LINK_FLIT_WIDTH = 32;
    localparam int LINK_DEST_WIDTH = 6;

    typedef struct packed {
        logic [LINK_FLIT_WIDTH-1:0] data;
        logic [LINK_DEST_WIDTH-1:0] dest;
        logic                       tail;
    } link_flit_t;

    // Enough bits to hold every value from 0 up to and including depth.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : noc_credit_counter
// Purpose  : Up/down credit counter, resets to DEPTH, saturates at DEPTH and
//            flags an overflow when a return arrives while already full.
// Revision : 1.0 - initial release
// ============================================================================
module noc_credit_counter
    import noc_link_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = credit_width(DEPTH)
) (
    input  logic             clk_noc,
    input  logic             rst_n,
    input  logic             dec,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] c_DEPTH = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    assign count = r_count;

    always_comb begin
        overflow = inc && !dec && (r_count == c_DEPTH);
    end

    // Simultaneous dec and inc cancel; underflow is guarded even though the
    // transmitter never decrements at zero.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= c_DEPTH;
        end else if (inc && !dec && (r_count != c_DEPTH)) begin
            r_count <= r_count + c_ONE;
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_credit_link_tx.sv
`default_nettype none
// ============================================================================
// Module   : noc_credit_link_tx
// Purpose  : Upstream end of a credit-based router link with wormhole dest
//            locking. Optional error tracking under NOC_LINK_TX_ERR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module noc_credit_link_tx
    import noc_link_pkg::*;
#(
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int CREDIT_WIDTH      = credit_width(FLIT_BUFFER_DEPTH)
) (
    input  logic                    clk_noc,
    input  logic                    rst_n,
    input  logic                    flit_valid,
    output logic                    flit_ready,
    input  logic [FLIT_WIDTH-1:0]   flit_data,
    input  logic [DEST_WIDTH-1:0]   flit_dest,
    input  logic                    flit_tail,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    in_packet
`ifdef NOC_LINK_TX_ERR_CHECK_EN
    ,
    output logic                    err_sticky
`endif
);

    localparam logic [0:0] c_ST_IDLE   = IDLE;
    localparam logic [0:0] c_ST_IN_PKT = IN_PKT;

    logic [0:0]            r_state;
    logic [DEST_WIDTH-1:0] r_head_dest;
    logic                  w_accept;
    logic                  w_overflow;
    logic [DEST_WIDTH-1:0] w_dest_sel;

    noc_credit_counter #(
        .DEPTH (FLIT_BUFFER_DEPTH),
        .WIDTH (CREDIT_WIDTH)
    ) u_credit_counter (
        .clk_noc  (clk_noc),
        .rst_n    (rst_n),
        .dec      (w_accept),
        .inc      (credit_in),
        .count    (credit_count),
        .overflow (w_overflow)
    );

    // Ready comes from the credit register alone, never from credit_in.
    assign flit_ready = (credit_count != '0);
    assign w_accept   = flit_valid && flit_ready;
    assign in_packet  = (r_state == c_ST_IN_PKT);
    assign w_dest_sel = (r_state == c_ST_IDLE) ? flit_dest : r_head_dest;

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_head_dest <= '0;
        end else if (w_accept) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!flit_tail) begin
                        r_state     <= c_ST_IN_PKT;
                        r_head_dest <= flit_dest;
                    end
                end
                c_ST_IN_PKT: begin
                    if (flit_tail) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= '0;
            dest_out    <= '0;
            is_tail_out <= 1'b0;
            send_out    <= 1'b0;
        end else begin
            send_out <= w_accept;
            if (w_accept) begin
                data_out    <= flit_data;
                dest_out    <= w_dest_sel;
                is_tail_out <= flit_tail;
            end
        end
    end

`ifdef NOC_LINK_TX_ERR_CHECK_EN
    logic w_dest_err;

    assign w_dest_err = w_accept && (r_state == c_ST_IN_PKT) && (flit_dest != r_head_dest);

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (w_overflow || w_dest_err) begin
            err_sticky <= 1'b1;
        end
    end
`else
    // Overflow saturates silently in this build.
    logic w_unused_overflow;
    assign w_unused_overflow = w_overflow;
`endif

endmodule
`default_nettype wire
